// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Holds state encodings, requester IDs and default widths and latency.
package mem_port_arbiter_pkg;

  localparam int SA_WIDTH   = 8;
  localparam int D_WIDTH    = 32;
  localparam int ARB_RD_LAT = 2;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic [1:0] {
    ARB_S_IDLE   = 2'd0,
    ARB_S_ACCESS = 2'd1,
    ARB_S_WAIT   = 2'd2,
    ARB_S_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory model view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = SA_WIDTH,
  parameter int DW = D_WIDTH
);

  logic [1:0]      Req;
  logic [1:0]      ReqRW;
  logic [2*AW-1:0] ReqAddr;
  logic [2*DW-1:0] ReqWData;
  logic [1:0]      Gnt;
  logic [1:0]      RValid;
  logic [DW-1:0]   RData;
  logic            Busy;
  logic [AW-1:0]   Mem_Addr;
  logic [DW-1:0]   Mem_WData;
  logic            Mem_RW;
  logic            Mem_En;
  logic [DW-1:0]   Mem_RData;

  modport slave (
    input  Req, ReqRW, ReqAddr, ReqWData, Mem_RData,
    output Gnt, RValid, RData, Busy, Mem_Addr, Mem_WData, Mem_RW, Mem_En
  );

  modport master (
    output Req, ReqRW, ReqAddr, ReqWData, Mem_RData,
    input  Gnt, RValid, RData, Busy, Mem_Addr, Mem_WData, Mem_RW, Mem_En
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// With both requests active the prio requester wins, otherwise the lone requester.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? prio : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the GPP path (0) and the loader/debug path (1).
// Round-robin grant, registered memory-side signals, fixed-latency read return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = SA_WIDTH,
  parameter int DW     = D_WIDTH,
  parameter int RD_LAT = ARB_RD_LAT  // legal range 1..4
) (
  input  logic              Clk,
  input  logic              Rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] LP_CNT_INIT = 2'(RD_LAT - 1);

  arb_state_t    r_state, w_state_next;
  logic          r_prio, w_prio_next;
  logic          r_winner, w_winner_next;
  logic          r_rw, w_rw_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [DW-1:0] r_wdata, w_wdata_next;
  logic [DW-1:0] r_rdata, w_rdata_next;
  logic [1:0]    r_cnt, w_cnt_next;

  logic          w_pick_valid;
  logic          w_pick_winner;
  logic          w_sel_rw;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [1:0]    w_gnt;
  logic [1:0]    w_rvalid;

  rr_pick2 u_pick (
    .req    (bus.Req),
    .prio   (r_prio),
    .valid  (w_pick_valid),
    .winner (w_pick_winner)
  );

  assign w_sel_rw    = w_pick_winner ? bus.ReqRW[1] : bus.ReqRW[0];
  assign w_sel_addr  = w_pick_winner ? bus.ReqAddr[2*AW-1:AW] : bus.ReqAddr[AW-1:0];
  assign w_sel_wdata = w_pick_winner ? bus.ReqWData[2*DW-1:DW] : bus.ReqWData[DW-1:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ARB_S_IDLE;
      r_prio   <= REQ_CPU;
      r_winner <= REQ_CPU;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_prio   <= w_prio_next;
      r_winner <= w_winner_next;
      r_rw     <= w_rw_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
      r_rdata  <= w_rdata_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_prio_next   = r_prio;
    w_winner_next = r_winner;
    w_rw_next     = r_rw;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_rdata_next  = r_rdata;
    w_cnt_next    = r_cnt;
    case (r_state)
      // RESP arbitrates like IDLE so a re-armed request goes straight to ACCESS.
      ARB_S_IDLE, ARB_S_RESP: begin
        w_state_next = ARB_S_IDLE;
        if (w_pick_valid) begin
          w_winner_next = w_pick_winner;
          w_rw_next     = w_sel_rw;
          w_addr_next   = w_sel_addr;
          w_wdata_next  = w_sel_wdata;
          w_state_next  = ARB_S_ACCESS;
        end
      end
      ARB_S_ACCESS: begin
        w_prio_next = ~r_winner;
        if (r_rw) begin
          w_state_next = ARB_S_IDLE;
        end else begin
          w_cnt_next   = LP_CNT_INIT;
          w_state_next = ARB_S_WAIT;
        end
      end
      ARB_S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_rdata_next = bus.Mem_RData;
          w_state_next = ARB_S_RESP;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      default: w_state_next = ARB_S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_gnt[gi]    = (r_state == ARB_S_ACCESS) && (r_winner == 1'(gi));
    assign w_rvalid[gi] = (r_state == ARB_S_RESP) && (r_winner == 1'(gi));
  end

  assign bus.Gnt       = w_gnt;
  assign bus.RValid    = w_rvalid;
  assign bus.RData     = r_rdata;
  assign bus.Busy      = (r_state != ARB_S_IDLE);
  assign bus.Mem_En    = (r_state == ARB_S_ACCESS);
  assign bus.Mem_Addr  = r_addr;
  assign bus.Mem_WData = r_wdata;
  assign bus.Mem_RW    = r_rw;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single processor memory port (address, read data, RW, enable) between two requesters.
- Requester 0 is the GPP fetch/load path. Requester 1 is the program loader/debug path that fills instruction memory before and between runs.
- Uses round-robin arbitration, a registered memory-side interface and a fixed-latency read-return path.
- Sits between the requesters and the memory model, replacing direct GPP-to-memory wiring.

Parameters:
- AW, 8: memory address width; tie to SA_WIDTH.
- DW, 32: data width; tie to D_WIDTH.
- RD_LAT, 2: memory read latency in cycles, legal range 1..4.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- Req  in  2  request per requester; bit i = requester i
- ReqRW  in  2  per-requester access type: 1 = write, 0 = read
- ReqAddr  in  2*AW  per-requester address; requester i at [i*AW +: AW]
- ReqWData  in  2*DW  per-requester write data; requester i at [i*DW +: DW]
- Gnt  out  2  one-cycle grant pulse
- RValid  out  2  one-cycle read-data-valid pulse
- RData  out  DW  last returned read data
- Busy  out  1  high whenever state is not S_IDLE
- Mem_Addr  out  AW  memory address
- Mem_WData  out  DW  memory write data
- Mem_RW  out  1  memory access type
- Mem_En  out  1  memory enable
- Mem_RData  in  DW  memory read data

Behaviour:
- Reset and clock: Rst is synchronous and active-high; clock is Clk; all state updates on posedge Clk.
- Reset values: all outputs 0, state S_IDLE, priority pointer prio = 0, wait counter 0, latched request fields 0.
- States: S_IDLE, S_ACCESS, S_WAIT, S_RESP; 2-bit encoding.
- Arbitration, evaluated in S_IDLE and S_RESP only:
  - no Req: stay in or go to S_IDLE.
  - one Req: that requester wins.
  - both Req: requester prio wins.
  - On a win: latch winner ID, ReqRW, ReqAddr and ReqWData of the winner; next state S_ACCESS.
- S_ACCESS (exactly one cycle):
  - Mem_En=1; Mem_Addr, Mem_RW, Mem_WData driven from registered latches.
  - Gnt[winner]=1 this cycle only.
  - prio <= ~winner.
  - Write: committed at the end of this cycle; next state S_IDLE; no RValid.
  - Read: counter <= RD_LAT-1; next state S_WAIT.
- S_WAIT:
  - Mem_En=0.
  - Counter decrements each cycle; the memory presents Mem_RData in the cycle the counter reads 0.
  - In that cycle the arbiter captures RData <= Mem_RData; next state S_RESP.
  - S_WAIT therefore spans RD_LAT cycles.
- S_RESP (one cycle):
  - RValid[winner]=1; RData holds the captured value and stays stable until the next read capture.
  - Arbitration runs in the same cycle, so a new request goes straight to S_ACCESS.
- Timing:
  - Read: Req sampled in cycle 0, Gnt/Mem_En in cycle 1, RValid in cycle RD_LAT+2.
  - Write: Gnt/Mem_En in cycle 1.
- Requester rules:
  - Hold Req, ReqRW, ReqAddr and ReqWData stable until Gnt.
  - Deassert or re-arm Req in the cycle after Gnt.
  - A Req still high in S_RESP, or in S_IDLE after a write, is a new request.
- Req changes during S_ACCESS or S_WAIT are ignored; the latched fields are used.
- Exactly one Mem_En pulse per grant; Gnt and Mem_En are always coincident.
- At most one Gnt bit and at most one RValid bit high in any cycle.
- Fairness: under continuous requests from both, grants strictly alternate; no requester waits more than one transaction.
- Reset mid-operation (any state): return to S_IDLE the next cycle; an in-flight read is dropped (no RValid); Mem_En=0; prio=0.
- Busy = (state != S_IDLE).

Decomposition:
- Shared header alongside define.h:
  - ARB_S_IDLE/ACCESS/WAIT/RESP state encodings.
  - REQ_CPU=0, REQ_LOAD=1 requester IDs.
  - ARB_RD_LAT default.
  - Width macros reused from SA_WIDTH and D_WIDTH.
- One sub-module: rr_pick2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], prio.
  - Outputs: valid, winner.
- Top level holds the FSM, latches, counter and return path.

Test Plan (RD_LAT=2):
- Reset: assert Rst 2 cycles with Req=2'b11 -> all outputs 0 throughout, Busy=0; after release, the first grant goes to requester 0.
- Single read: Req[0]=1, ReqAddr0=0x05, memory holds 0x2002000A -> cycle 1: Gnt=01, Mem_En=1, Mem_Addr=0x05, Mem_RW=0; cycle 4: RValid=01, RData=0x2002000A.
- Write then readback: requester 1 writes 0x03 <- 0xDEADBEEF -> one Mem_En cycle with Mem_RW=1, Mem_WData=0xDEADBEEF, no RValid; a subsequent requester 1 read of 0x03 -> RValid=10, RData=0xDEADBEEF.
- Contention: both request writes, held continuously for 4 transactions -> Gnt sequence 01,10,01,10, one cycle gap between grants, no overlapping Mem_En.
- Back-to-back reads: requester 0 re-requests in S_RESP -> next Gnt in the cycle after RValid, a 4-cycle read period.
- Reset mid-read: Rst asserted while in S_WAIT -> no RValid ever for that read, S_IDLE next cycle, prio=0, next contended grant to requester 0.
